// File: rtl/gemm_pkg.sv
// gemm_pkg -- definitions shared by the GEMM datapath blocks.
//   SEL_*          : encodings of the systolic array acc_mux_sel input
//   feeder_state_e : tile sequencing states of systolic_skew_feeder
//   max_int        : elaboration-time helper for sizing counters
package gemm_pkg;

  localparam logic [1:0] SEL_ACC   = 2'b00;
  localparam logic [1:0] SEL_SOUTH = 2'b01;
  localparam logic [1:0] SEL_EAST  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DRAIN,
    ST_FLUSH,
    ST_DONE
  } feeder_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line -- fixed-depth register delay line with zero fill.
// When valid_i is low a zero is shifted in instead of data_i, so the
// output reads zero everywhere outside the window of valid samples.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears every stage
//   valid_i : data_i qualifier for the current cycle
//   data_i  : sample entering the line
//   data_o  : sample delayed by Depth cycles
module skew_delay_line #(
  parameter int Depth = 1,
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  logic [Width-1:0] stage_reg [Depth];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int d = 0; d < Depth; d++) begin
        stage_reg[d] <= '0;
      end
    end else begin
      stage_reg[0] <= valid_i ? data_i : '0;
      for (int d = 1; d < Depth; d++) begin
        stage_reg[d] <= stage_reg[d-1];
      end
    end
  end

  assign data_o = stage_reg[Depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder -- reads one K-deep GEMM tile from the A and B
// operand SRAMs and presents it diagonally skewed to the west (A) and
// north (B) edges of an N x N systolic array, then sequences the drain
// and east-ward flush of the accumulated results.
//   clk_i / rst_i       : clock, synchronous active-high reset
//   start_i             : tile start, honoured only while idle
//   sram_a/b_rdata_i    : A column k / B row k, one lane per array row/col
//   sram_rd_en_o/addr_o : shared read port control (1-cycle latency SRAM)
//   a_skew_o / b_skew_o : lane i delayed by i+1 cycles behind the SRAM data
//   valid_data_o        : high while any lane carries operand data
//   acc_mux_sel_o       : SEL_EAST during flush, SEL_ACC otherwise
//   busy_o / done_o     : tile in progress / single-cycle completion pulse
module systolic_skew_feeder
  import gemm_pkg::*;
#(
  parameter  int NumInputs   = 4,
  parameter  int InDataWidth = 8,
  parameter  int KDepth      = 4,
  localparam int AddrWidth   = (KDepth > 1) ? $clog2(KDepth) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        start_i,
  input  logic signed [NumInputs-1:0][InDataWidth-1:0] sram_a_rdata_i,
  input  logic signed [NumInputs-1:0][InDataWidth-1:0] sram_b_rdata_i,
  output logic                                        sram_rd_en_o,
  output logic        [AddrWidth-1:0]                 sram_rd_addr_o,
  output logic signed [NumInputs-1:0][InDataWidth-1:0] a_skew_o,
  output logic signed [NumInputs-1:0][InDataWidth-1:0] b_skew_o,
  output logic                                        valid_data_o,
  output logic        [1:0]                           acc_mux_sel_o,
  output logic                                        busy_o,
  output logic                                        done_o
);

  // One counter serves every timed state; the longest is WAIT (N+1 cycles).
  localparam int CntMax   = max_int(KDepth, NumInputs + 1);
  localparam int CntWidth = $clog2(CntMax + 1);

  localparam logic [CntWidth-1:0] FetchLast = CntWidth'(KDepth - 1);
  localparam logic [CntWidth-1:0] WaitLast  = CntWidth'(NumInputs);
  localparam logic [CntWidth-1:0] DrainLast = CntWidth'((NumInputs > 1) ? NumInputs - 2 : 0);
  localparam logic [CntWidth-1:0] FlushLast = CntWidth'(NumInputs - 1);

  feeder_state_e          state_reg;
  logic [CntWidth-1:0]    cnt_reg;
  logic                   rd_en_reg;
  logic [AddrWidth-1:0]   rd_addr_reg;
  logic [1:0]             sel_reg;
  logic                   busy_reg;
  logic                   done_reg;

  // rdata qualifier: the SRAM answers one cycle after the read request.
  logic                   rd_valid_reg;
  // Bit i is high while lane i's skew output holds operand data.
  logic [NumInputs-1:0]   lane_valid_reg;

  // Sequencer. Outputs are registered alongside the state so that each one
  // takes its new value in the same cycle the state changes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rd_en_reg   <= 1'b0;
      rd_addr_reg <= '0;
      sel_reg     <= SEL_ACC;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg   <= ST_FETCH;
            cnt_reg     <= '0;
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (cnt_reg == FetchLast) begin
            state_reg   <= ST_WAIT;
            cnt_reg     <= '0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
          end else begin
            cnt_reg     <= cnt_reg + 1'b1;
            rd_addr_reg <= rd_addr_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == WaitLast) begin
            cnt_reg <= '0;
            // A 1-wide array has no drain phase at all.
            if (NumInputs > 1) begin
              state_reg <= ST_DRAIN;
            end else begin
              state_reg <= ST_FLUSH;
              sel_reg   <= SEL_EAST;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt_reg == DrainLast) begin
            state_reg <= ST_FLUSH;
            cnt_reg   <= '0;
            sel_reg   <= SEL_EAST;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt_reg == FlushLast) begin
            state_reg <= ST_DONE;
            cnt_reg   <= '0;
            sel_reg   <= SEL_ACC;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          rd_en_reg <= 1'b0;
          sel_reg   <= SEL_ACC;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // valid_data_o follows the data through the skew, not the FSM: the flag
  // rides a shift register one stage per lane, ORed across lanes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_valid_reg   <= 1'b0;
      lane_valid_reg <= '0;
    end else begin
      rd_valid_reg   <= rd_en_reg;
      lane_valid_reg <= (lane_valid_reg << 1) | NumInputs'(rd_valid_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumInputs; gi++) begin : g_lane
      skew_delay_line #(
        .Depth (gi + 1),
        .Width (InDataWidth)
      ) u_a_skew (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (rd_valid_reg),
        .data_i  (sram_a_rdata_i[gi]),
        .data_o  (a_skew_o[gi])
      );

      skew_delay_line #(
        .Depth (gi + 1),
        .Width (InDataWidth)
      ) u_b_skew (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (rd_valid_reg),
        .data_i  (sram_b_rdata_i[gi]),
        .data_o  (b_skew_o[gi])
      );
    end
  endgenerate

  assign sram_rd_en_o   = rd_en_reg;
  assign sram_rd_addr_o = rd_addr_reg;
  assign valid_data_o   = |lane_valid_reg;
  assign acc_mux_sel_o  = sel_reg;
  assign busy_o         = busy_reg;
  assign done_o         = done_reg;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder -- directed bench for systolic_skew_feeder.
// Two instances: dut0 (N=4, K=4) and dut1 (N=4, K=1). Each has its own
// 1-cycle-latency SRAM model that returns 8'h55 junk when not reading, so
// zero fill of the skew lines is visible. "Cycle c" below is the clock
// period ending at edge c; start_i high in cycle 0 launches a tile, and
// outputs for cycle c are sampled 1 time unit after edge c-1.
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int K1 = 1;
  localparam int W  = 8;
  localparam int T  = K + 3 * N + 1;   // DONE cycle of a K=4 tile (17)

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start1;

  logic [N-1:0][W-1:0] a_rd0, b_rd0, a_rd1, b_rd1;
  logic [N-1:0][W-1:0] a_skew0, b_skew0, a_skew1, b_skew1;
  logic                rd_en0, rd_en1;
  logic [1:0]          rd_addr0;
  logic [0:0]          rd_addr1;
  logic                valid0, valid1, busy0, busy1, done0, done1;
  logic [1:0]          sel0, sel1;

  logic [W-1:0] a_mem [K][N];   // a_mem[k][i] = a[i][k]
  logic [W-1:0] b_mem [K][N];   // b_mem[k][j] = b[k][j]

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.NumInputs(N), .InDataWidth(W), .KDepth(K)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .sram_a_rdata_i(a_rd0), .sram_b_rdata_i(b_rd0),
    .sram_rd_en_o(rd_en0), .sram_rd_addr_o(rd_addr0),
    .a_skew_o(a_skew0), .b_skew_o(b_skew0),
    .valid_data_o(valid0), .acc_mux_sel_o(sel0),
    .busy_o(busy0), .done_o(done0)
  );

  systolic_skew_feeder #(.NumInputs(N), .InDataWidth(W), .KDepth(K1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1),
    .sram_a_rdata_i(a_rd1), .sram_b_rdata_i(b_rd1),
    .sram_rd_en_o(rd_en1), .sram_rd_addr_o(rd_addr1),
    .a_skew_o(a_skew1), .b_skew_o(b_skew1),
    .valid_data_o(valid1), .acc_mux_sel_o(sel1),
    .busy_o(busy1), .done_o(done1)
  );

  // Synchronous-read SRAM models.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      a_rd0[i] <= rd_en0 ? a_mem[rd_addr0][i] : 8'h55;
      b_rd0[i] <= rd_en0 ? b_mem[rd_addr0][i] : 8'h55;
      a_rd1[i] <= rd_en1 ? a_mem[rd_addr1][i] : 8'h55;
      b_rd1[i] <= rd_en1 ? b_mem[rd_addr1][i] : 8'h55;
    end
  end

  // Expected-timing model, cycle c counted from the start cycle.
  function automatic logic exp_rd(input int c, input int kk);
    return (c >= 1 && c <= kk);
  endfunction
  function automatic logic exp_valid(input int c, input int kk);
    return (c >= 3 && c <= kk + N + 1);
  endfunction
  function automatic logic exp_busy(input int c, input int kk);
    return (c >= 1 && c <= kk + 3 * N + 1);
  endfunction
  function automatic logic exp_done(input int c, input int kk);
    return (c == kk + 3 * N + 1);
  endfunction
  function automatic logic [1:0] exp_sel(input int c, input int kk);
    return (c >= kk + 2 * N + 1 && c <= kk + 3 * N) ? 2'b10 : 2'b00;
  endfunction
  function automatic logic [W-1:0] exp_a(input int c, input int i, input int kk);
    int k;
    k = c - 3 - i;
    return (k >= 0 && k < kk) ? a_mem[k][i] : '0;
  endfunction
  function automatic logic [W-1:0] exp_b(input int c, input int i, input int kk);
    int k;
    k = c - 3 - i;
    return (k >= 0 && k < kk) ? b_mem[k][i] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pattern(input int p);
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < N; i++) begin
        case (p)
          0: begin a_mem[k][i] = 8'(-(i * k));        b_mem[k][i] = 8'(i - 1); end
          1: begin a_mem[k][i] = 8'(16 * i + k - 40); b_mem[k][i] = 8'(7 * k - 3 * i + 1); end
          default: begin a_mem[k][i] = 8'h80;         b_mem[k][i] = 8'h7F; end
        endcase
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; start1 = 1'b1;
    load_pattern(0);
    step(); step(); step();
    n_total++;
    if ({rd_en0, rd_addr0, valid0, sel0, busy0, done0} !== 7'b0) begin
      $display("FAIL reset_ctrl: got rd=%b addr=%0d v=%b sel=%b busy=%b done=%b want all 0",
               rd_en0, rd_addr0, valid0, sel0, busy0, done0);
    end else n_pass++;
    n_total++;
    if (a_skew0 !== '0 || b_skew0 !== '0) begin
      $display("FAIL reset_skew: got a=%h b=%h want 0", a_skew0, b_skew0);
    end else n_pass++;
    n_total++;
    if ({rd_en1, rd_addr1, valid1, sel1, busy1, done1} !== 7'b0 || a_skew1 !== '0) begin
      $display("FAIL reset_k1: got rd=%b v=%b busy=%b done=%b want all 0", rd_en1, valid1, busy1, done1);
    end else n_pass++;
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_tile_patterns();
    for (int p = 0; p < 3; p++) begin
      load_pattern(p);
      start = 1'b1;
      for (int c = 1; c <= T + 1; c++) begin
        step();
        start = 1'b0;
        n_total++;
        if (rd_en0 !== exp_rd(c, K) || (exp_rd(c, K) && rd_addr0 !== 2'(c - 1))) begin
          $display("FAIL tile%0d_rd c=%0d: got en=%b addr=%0d want en=%b addr=%0d",
                   p, c, rd_en0, rd_addr0, exp_rd(c, K), c - 1);
        end else n_pass++;
        n_total++;
        if (valid0 !== exp_valid(c, K) || busy0 !== exp_busy(c, K) ||
            done0 !== exp_done(c, K) || sel0 !== exp_sel(c, K)) begin
          $display("FAIL tile%0d_ctrl c=%0d: got v=%b busy=%b done=%b sel=%b want v=%b busy=%b done=%b sel=%b",
                   p, c, valid0, busy0, done0, sel0,
                   exp_valid(c, K), exp_busy(c, K), exp_done(c, K), exp_sel(c, K));
        end else n_pass++;
        for (int i = 0; i < N; i++) begin
          n_total++;
          if (a_skew0[i] !== exp_a(c, i, K) || b_skew0[i] !== exp_b(c, i, K)) begin
            $display("FAIL tile%0d_lane%0d c=%0d: got a=%0d b=%0d want a=%0d b=%0d", p, i, c,
                     $signed(a_skew0[i]), $signed(b_skew0[i]),
                     $signed(exp_a(c, i, K)), $signed(exp_b(c, i, K)));
          end else n_pass++;
        end
        // Hand-derived spot values.
        if (p == 0 && c == 9) begin
          n_total++;
          if ($signed(a_skew0[3]) !== -9 || $signed(b_skew0[3]) !== 2) begin
            $display("FAIL tile0_spot c=9: got a3=%0d b3=%0d want -9 2",
                     $signed(a_skew0[3]), $signed(b_skew0[3]));
          end else n_pass++;
        end
        if (p == 0 && c == 17) begin
          n_total++;
          if (done0 !== 1'b1) $display("FAIL tile0_done c=17: got %b want 1", done0);
          else n_pass++;
        end
        if (p == 2 && c == 6) begin
          n_total++;
          if (a_skew0[3] !== 8'h80 || b_skew0[3] !== 8'h7F || a_skew0[0] !== 8'h80) begin
            $display("FAIL tile2_extreme c=6: got a3=%0d b3=%0d a0=%0d want -128 127 -128",
                     $signed(a_skew0[3]), $signed(b_skew0[3]), $signed(a_skew0[0]));
          end else n_pass++;
        end
      end
      $display("test_tile pattern %0d done", p);
    end
  endtask

  task automatic test_back_to_back();
    int lc;
    load_pattern(1);
    start = 1'b1;
    for (int c = 1; c <= 2 * (T + 1) + 1; c++) begin
      step();
      lc = (c < T + 1) ? c : c - (T + 1);
      n_total++;
      if (rd_en0 !== exp_rd(lc, K) || valid0 !== exp_valid(lc, K) || busy0 !== exp_busy(lc, K) ||
          done0 !== exp_done(lc, K) || sel0 !== exp_sel(lc, K)) begin
        $display("FAIL b2b_ctrl c=%0d: got rd=%b v=%b busy=%b done=%b sel=%b want rd=%b v=%b busy=%b done=%b sel=%b",
                 c, rd_en0, valid0, busy0, done0, sel0, exp_rd(lc, K), exp_valid(lc, K),
                 exp_busy(lc, K), exp_done(lc, K), exp_sel(lc, K));
      end else n_pass++;
      n_total++;
      if (a_skew0[N-1] !== exp_a(lc, N - 1, K) || b_skew0[1] !== exp_b(lc, 1, K)) begin
        $display("FAIL b2b_data c=%0d: got a3=%0d b1=%0d want a3=%0d b1=%0d", c,
                 $signed(a_skew0[N-1]), $signed(b_skew0[1]),
                 $signed(exp_a(lc, N - 1, K)), $signed(exp_b(lc, 1, K)));
      end else n_pass++;
      if (c == 2 * T + 1) start = 1'b0;   // drop before the idle cycle after the 2nd DONE
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_mid_reset();
    load_pattern(0);
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 7; c <= 24; c++) begin
      n_total++;
      if ({rd_en0, valid0, sel0, busy0, done0} !== 6'b0 || a_skew0 !== '0 || b_skew0 !== '0) begin
        $display("FAIL midrst_quiet c=%0d: got rd=%b v=%b sel=%b busy=%b done=%b a=%h want all 0",
                 c, rd_en0, valid0, sel0, busy0, done0, a_skew0);
      end else n_pass++;
      step();
    end
    start = 1'b1;
    for (int c = 1; c <= T + 1; c++) begin
      step();
      start = 1'b0;
      n_total++;
      if (rd_en0 !== exp_rd(c, K) || valid0 !== exp_valid(c, K) || busy0 !== exp_busy(c, K) ||
          done0 !== exp_done(c, K) || a_skew0[N-1] !== exp_a(c, N - 1, K) || b_skew0[2] !== exp_b(c, 2, K)) begin
        $display("FAIL midrst_restart c=%0d: got rd=%b v=%b busy=%b done=%b a3=%0d b2=%0d", c,
                 rd_en0, valid0, busy0, done0, $signed(a_skew0[N-1]), $signed(b_skew0[2]));
      end else n_pass++;
    end
    $display("test_mid_reset done");
  endtask

  task automatic test_k1();
    load_pattern(1);
    start1 = 1'b1;
    for (int c = 1; c <= K1 + 3 * N + 2; c++) begin
      step();
      start1 = 1'b0;
      n_total++;
      if (rd_en1 !== exp_rd(c, K1) || (rd_en1 && rd_addr1 !== 1'b0) || valid1 !== exp_valid(c, K1) ||
          busy1 !== exp_busy(c, K1) || done1 !== exp_done(c, K1) || sel1 !== exp_sel(c, K1)) begin
        $display("FAIL k1_ctrl c=%0d: got rd=%b v=%b busy=%b done=%b sel=%b want rd=%b v=%b busy=%b done=%b sel=%b",
                 c, rd_en1, valid1, busy1, done1, sel1, exp_rd(c, K1), exp_valid(c, K1),
                 exp_busy(c, K1), exp_done(c, K1), exp_sel(c, K1));
      end else n_pass++;
      for (int i = 0; i < N; i++) begin
        n_total++;
        if (a_skew1[i] !== exp_a(c, i, K1) || b_skew1[i] !== exp_b(c, i, K1)) begin
          $display("FAIL k1_lane%0d c=%0d: got a=%0d b=%0d want a=%0d b=%0d", i, c,
                   $signed(a_skew1[i]), $signed(b_skew1[i]),
                   $signed(exp_a(c, i, K1)), $signed(exp_b(c, i, K1)));
        end else n_pass++;
      end
      if (c == 14) begin
        n_total++;
        if (done1 !== 1'b1) $display("FAIL k1_done c=14: got %b want 1", done1);
        else n_pass++;
      end
    end
    $display("test_k1 done");
  endtask

  initial begin
    test_reset();
    test_tile_patterns();
    test_back_to_back();
    test_mid_reset();
    test_k1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 SHALL have parameter NumInputs, default 4, meaning array edge length N (lanes per operand).
REQ-002 SHALL have parameter InDataWidth, default 8, meaning signed operand width.
REQ-003 SHALL have parameter KDepth, default 4, meaning reduction length K (SRAM words per tile), K>=1.
REQ-004 SHALL have derived AddrWidth = max(1, $clog2(KDepth)).
REQ-005 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 start_i  in  1  tile start request; sampled only in IDLE.
REQ-008 sram_a_rdata_i  in  [NumInputs][InDataWidth] signed  A column k: lane i = a[i][k].
REQ-009 sram_b_rdata_i  in  [NumInputs][InDataWidth] signed  B row k: lane j = b[k][j].
REQ-010 sram_rd_en_o  out  1  SRAM read enable for A and B.
REQ-011 sram_rd_addr_o  out  AddrWidth  k index of the read.
REQ-012 a_skew_o  out  [NumInputs][InDataWidth] signed  skewed A to the array west edge.
REQ-013 b_skew_o  out  [NumInputs][InDataWidth] signed  skewed B to the array north edge.
REQ-014 valid_data_o  out  1  drives the array valid_data input.
REQ-015 acc_mux_sel_o  out  2  drives the array acc_mux_sel input.
REQ-016 busy_o  out  1  tile in progress.
REQ-017 done_o  out  1  one-cycle pulse when the tile's results have been fully flushed.

Function
REQ-018 Cycle numbering: cycle 0 = edge where start_i=1 is sampled in IDLE.
REQ-019 FSM states: IDLE, FETCH, WAIT, DRAIN, FLUSH, DONE; single counter sized for max(K, N+1).
REQ-020 FETCH occupies cycles 1..K: sram_rd_en_o=1, sram_rd_addr_o=cycle-1; sram_rd_en_o=0 in all other states.
REQ-021 SRAM read latency is fixed at 1: data for address k is valid on rdata inputs in cycle k+2.
REQ-022 Lane i of a_skew_o/b_skew_o SHALL output a[i][k]/b[k][i] in cycle k+3+i (i+1 register stages), unmodified, sign preserved.
REQ-023 Skew registers SHALL shift in zero whenever rdata is not in its valid window; every lane outputs 0 outside its data slot.
REQ-024 valid_data_o=1 exactly in cycles 3..K+N+1, derived from a delayed flag, not from state.
REQ-025 WAIT occupies cycles K+1..K+N+1; DRAIN cycles K+N+2..K+2N (N-1 cycles); FLUSH cycles K+2N+1..K+3N (N cycles); DONE cycle K+3N+1, then IDLE.
REQ-026 acc_mux_sel_o = SEL_EAST (2'b10) in FLUSH, SEL_ACC (2'b00) in every other state.
REQ-027 busy_o=1 in every state except IDLE; done_o=1 only in DONE.
REQ-028 start_i asserted in any state other than IDLE is ignored, with no queuing.
REQ-029 start_i asserted in the cycle after DONE (IDLE) starts a new tile; no minimum idle gap.
REQ-030 With K=1: FETCH lasts one cycle and all timing in REQ-020..REQ-025 holds unchanged.

Reset
REQ-031 rst_i=1 at any edge, including mid-tile, SHALL force IDLE, clear counter, skew registers and valid delay flag; done_o is not pulsed.
REQ-032 Reset values: sram_rd_en_o=0, sram_rd_addr_o=0, a_skew_o=0, b_skew_o=0, valid_data_o=0, acc_mux_sel_o=2'b00, busy_o=0, done_o=0.

Structure
REQ-033 Shared package gemm_pkg SHALL hold the acc_mux_sel encodings SEL_ACC=2'b00, SEL_SOUTH=2'b01, SEL_EAST=2'b10, and the FSM state enum.
REQ-034 One sub-module, skew_delay_line (parameterised depth and width, zero-fill on invalid), SHALL be instantiated per lane per operand.

Verification
REQ-035 Reset then start with K=N=4, a[i][k]=-(i*k), b[k][j]=j-1 -> lane 3 a_skew_o=-9 at cycle 9; valid_data_o high cycles 3..9; done_o pulses at cycle 17.
REQ-036 Chain to gemm_systolic_array_top, same data -> flushed east outputs equal software C=A*B for all 16 entries.
REQ-037 start_i held high for the whole tile -> exactly one tile; second tile begins at cycle 18 with an identical waveform.
REQ-038 rst_i pulsed at cycle 6 -> all outputs 0 from cycle 7; no done_o; next start_i behaves as from cold reset.
REQ-039 KDepth=1, NumInputs=4 -> rd_en only in cycle 1; valid_data_o high cycles 3..6; done_o at cycle 14.
REQ-040 Operands -128 and 127 in all lanes -> outputs bit-exact and sign-correct; all non-slot lane cycles read 0.
